// File: rtl/io_bus_pkg.sv
// io_bus_pkg: register offsets, SPI_CTRL field positions and sequencer states for io_bus
package io_bus_pkg;
    localparam logic [7:0] REG_OUT        = 8'h00;
    localparam logic [7:0] REG_IN         = 8'h01;
    localparam logic [7:0] REG_GPIO_DIR   = 8'h02;
    localparam logic [7:0] REG_GPIO_IN    = 8'h03;
    localparam logic [7:0] REG_GPIO_OUT   = 8'h04;
    localparam logic [7:0] REG_SPI_CTRL   = 8'h05;
    localparam logic [7:0] REG_SPI_STATUS = 8'h06;
    localparam logic [7:0] REG_SPI_TX     = 8'h08;
    localparam logic [7:0] REG_SPI_RX     = 8'h0C;
    localparam logic [7:0] REG_IRQ_EN     = 8'h18;
    localparam logic [7:0] REG_IRQ_PEND   = 8'h19;
    localparam logic [7:0] REG_IRQ_EDGE   = 8'h1A;

    localparam int CTRL_START  = 0;
    localparam int CTRL_NB_LSB = 1;
    localparam int CTRL_CS_LSB = 3;

    typedef enum logic [1:0] {IDLE, SPI_WAIT, DONE} state_t;
endpackage

// File: rtl/gpio_edge_irq.sv
// gpio_edge_irq: GPIO input synchroniser, per-pin edge detect and pending/enable interrupt registers
module gpio_edge_irq #(
    parameter int NUM_GPIO = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_GPIO-1:0] io_inputs,
    input  logic [NUM_GPIO-1:0] dir,
    input  logic [NUM_GPIO-1:0] wdata,
    input  logic                en_we,
    input  logic                pend_w1c,
    input  logic                edge_we,
    output logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] irq_en,
    output logic [NUM_GPIO-1:0] irq_pend,
    output logic [NUM_GPIO-1:0] irq_edge,
    output logic                irq
);
    logic [NUM_GPIO-1:0] s1, s2, prev, hit;

    assign gpio_in = s2 & ~dir;
    assign hit     = (irq_edge & prev & ~gpio_in) | (~irq_edge & ~prev & gpio_in);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            prev     <= '0;
            irq_en   <= '0;
            irq_edge <= '0;
            irq_pend <= '0;
            irq      <= 1'b0;
        end else begin
            s1   <= io_inputs;
            s2   <= s1;
            prev <= gpio_in;
            if (en_we) irq_en <= wdata;
            if (edge_we) irq_edge <= wdata;
            // a new edge wins over a simultaneous write-1-to-clear
            irq_pend <= (irq_pend & ~(pend_w1c ? wdata : '0)) | hit;
            irq      <= |(irq_pend & irq_en);
        end
    end
endmodule

// File: rtl/io_bus.sv
// io_bus: I/O register block with GPIO, chip-select outputs and SPI peripheral sequencing
module io_bus
    import io_bus_pkg::*;
#(
    parameter int NUM_GPIO = 7,
    parameter int NUM_OUT  = 4,
    parameter int NUM_IN   = 5,
    parameter int NUM_CS   = 4,
    parameter int ADDR_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_request,
    input  logic                is_write,
    input  logic [ADDR_W-1:0]   target_address,
    input  logic [31:0]         write_value,
    output logic [31:0]         fetched_value,
    output logic                request_done,
    input  logic [NUM_IN-1:0]   inputs,
    output logic [NUM_OUT-1:0]  outputs,
    input  logic [NUM_GPIO-1:0] io_inputs,
    output logic [NUM_GPIO-1:0] io_outputs,
    output logic [NUM_GPIO-1:0] io_direction,
    output logic                irq,
    output logic                spi_start,
    output logic [2:0]          spi_num_bytes,
    output logic [31:0]         spi_tx_data,
    input  logic [31:0]         spi_rx_data,
    input  logic                spi_done,
    input  logic                spi_busy
);
    state_t state, next;
    logic [NUM_IN-1:0]   in_s1, in_s2;
    logic [NUM_OUT-1:0]  out_reg;
    logic [NUM_GPIO-1:0] dir, gpio_out, gpio_in, irq_en, irq_pend, irq_edge;
    logic [NUM_CS-1:0]   cs_sel;
    logic [1:0]          nbytes;
    logic [31:0]         spi_tx, spi_rx, rd_data;
    logic                spi_done_flag, aborted, accept, wr, spi_go;

    function automatic logic at(input logic [7:0] off);
        return target_address == ADDR_W'(off);
    endfunction

    assign accept = state == IDLE && start_request;
    assign wr     = accept && is_write;
    assign spi_go = wr && at(REG_SPI_CTRL) && write_value[CTRL_START];

    gpio_edge_irq #(.NUM_GPIO(NUM_GPIO)) u_irq (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_inputs(io_inputs),
        .dir      (dir),
        .wdata    (write_value[NUM_GPIO-1:0]),
        .en_we    (wr && at(REG_IRQ_EN)),
        .pend_w1c (wr && at(REG_IRQ_PEND)),
        .edge_we  (wr && at(REG_IRQ_EDGE)),
        .gpio_in  (gpio_in),
        .irq_en   (irq_en),
        .irq_pend (irq_pend),
        .irq_edge (irq_edge),
        .irq      (irq)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:     next = accept ? (spi_go ? SPI_WAIT : DONE) : IDLE;
            SPI_WAIT: next = spi_done ? ((aborted || !start_request) ? IDLE : DONE) : SPI_WAIT;
            DONE:     next = start_request ? DONE : IDLE;
            default:  next = IDLE;
        endcase
    end

    always_comb begin
        request_done  = state == DONE;
        spi_start     = state == SPI_WAIT;
        spi_num_bytes = {1'b0, nbytes} + 3'd1;
        spi_tx_data   = spi_tx;
        io_outputs    = gpio_out;
        io_direction  = dir;
        outputs       = out_reg;
        for (int i = 0; i < NUM_CS; i++)
            if (cs_sel[i]) outputs[i] = ~(spi_start & spi_busy);
    end

    always_comb begin
        rd_data = at(REG_OUT)        ? 32'(out_reg)  :
                  at(REG_IN)         ? 32'(in_s2)    :
                  at(REG_GPIO_DIR)   ? 32'(dir)      :
                  at(REG_GPIO_IN)    ? 32'(gpio_in)  :
                  at(REG_GPIO_OUT)   ? 32'(gpio_out) :
                  at(REG_SPI_STATUS) ? {30'd0, spi_busy, spi_done_flag} :
                  at(REG_SPI_TX)     ? spi_tx        :
                  at(REG_SPI_RX)     ? spi_rx        :
                  at(REG_IRQ_EN)     ? 32'(irq_en)   :
                  at(REG_IRQ_PEND)   ? 32'(irq_pend) :
                  at(REG_IRQ_EDGE)   ? 32'(irq_edge) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_s1         <= '0;
            in_s2         <= '0;
            out_reg       <= '0;
            dir           <= '0;
            gpio_out      <= '0;
            cs_sel        <= '0;
            nbytes        <= '0;
            spi_tx        <= '0;
            spi_rx        <= '0;
            spi_done_flag <= 1'b0;
            aborted       <= 1'b0;
            fetched_value <= '0;
        end else begin
            in_s1   <= inputs;
            in_s2   <= in_s1;
            // remembers a requester that gave up while the transfer was in flight
            aborted <= state == SPI_WAIT && !spi_done && (aborted || !start_request);
            if (accept && !is_write) fetched_value <= rd_data;
            if (wr && at(REG_OUT)) out_reg <= write_value[NUM_OUT-1:0];
            if (wr && at(REG_GPIO_DIR)) dir <= write_value[NUM_GPIO-1:0];
            if (wr && at(REG_GPIO_OUT)) gpio_out <= write_value[NUM_GPIO-1:0] & dir;
            if (wr && at(REG_SPI_TX)) spi_tx <= write_value;
            if (wr && at(REG_SPI_CTRL)) cs_sel <= write_value[CTRL_CS_LSB +: NUM_CS];
            if (spi_go) begin
                nbytes        <= write_value[CTRL_NB_LSB +: 2];
                spi_done_flag <= 1'b0;
            end
            if (state == SPI_WAIT && spi_done) begin
                spi_rx        <= spi_rx_data;
                spi_done_flag <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_io_bus.sv
// tb_io_bus: directed checks of io_bus registers, GPIO, interrupts and SPI sequencing
module tb_io_bus;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_request = 1'b0;
    logic        is_write = 1'b0;
    logic [7:0]  target_address = '0;
    logic [31:0] write_value = '0;
    logic [31:0] fetched_value;
    logic        request_done;
    logic [4:0]  inputs = '0;
    logic [3:0]  outputs;
    logic [6:0]  io_inputs = '0;
    logic [6:0]  io_outputs;
    logic [6:0]  io_direction;
    logic        irq;
    logic        spi_start;
    logic [2:0]  spi_num_bytes;
    logic [31:0] spi_tx_data;
    logic [31:0] spi_rx_data = '0;
    logic        spi_done = 1'b0;
    logic        spi_busy = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    io_bus dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_request (start_request),
        .is_write      (is_write),
        .target_address(target_address),
        .write_value   (write_value),
        .fetched_value (fetched_value),
        .request_done  (request_done),
        .inputs        (inputs),
        .outputs       (outputs),
        .io_inputs     (io_inputs),
        .io_outputs    (io_outputs),
        .io_direction  (io_direction),
        .irq           (irq),
        .spi_start     (spi_start),
        .spi_num_bytes (spi_num_bytes),
        .spi_tx_data   (spi_tx_data),
        .spi_rx_data   (spi_rx_data),
        .spi_done      (spi_done),
        .spi_busy      (spi_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // called at a negedge; returns at a negedge with the request released
    task automatic bus(input logic we, input logic [7:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat);
        is_write = we;
        target_address = a;
        write_value = wd;
        start_request = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!request_done && lat < 20);
        chk("req_done", 32'(request_done), 32'd1);
        rd = fetched_value;
        start_request = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int lat;
        bus(1'b1, a, d, rd, lat);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        int lat;
        bus(1'b0, a, '0, rd, lat);
        chk(tag, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        int lat;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(request_done), 0);
        chk("rst_spi_start", 32'(spi_start), 0);
        chk("rst_outputs", 32'(outputs), 0);
        chk("rst_io_out", 32'(io_outputs), 0);
        chk("rst_io_dir", 32'(io_direction), 0);
        chk("rst_irq", 32'(irq), 0);
        rst_n = 1'b1;
        @(negedge clk);

        wr(8'h00, 32'h5);
        chk("out_reg", 32'(outputs), 32'h5);
        bus(1'b1, 8'h02, 32'h0F, rd, lat);
        chk("wr_latency", 32'(lat), 1);
        wr(8'h04, 32'h7F);
        chk("io_outputs", 32'(io_outputs), 32'h0F);
        chk("io_direction", 32'(io_direction), 32'h0F);
        rd_chk("rd_gpio_out", 8'h04, 32'h0F);
        bus(1'b0, 8'h02, '0, rd, lat);
        chk("rd_latency", 32'(lat), 1);
        chk("rd_dir", rd, 32'h0F);

        io_inputs = 7'h50;
        inputs = 5'h13;
        repeat (3) @(negedge clk);
        rd_chk("rd_gpio_in", 8'h03, 32'h50);
        rd_chk("rd_in", 8'h01, 32'h13);
        rd_chk("rd_unmapped", 8'h30, 0);
        rd_chk("rd_spi_ctrl_wo", 8'h05, 0);
        rd_chk("pend_rise_4_6", 8'h19, 32'h50);
        wr(8'h19, 32'h7F);
        rd_chk("pend_w1c_all", 8'h19, 0);

        wr(8'h08, 32'hDDCCBBAA);
        rd_chk("rd_spi_tx", 8'h08, 32'hDDCCBBAA);
        is_write = 1'b1;
        target_address = 8'h05;
        write_value = 32'h15;
        start_request = 1'b1;
        @(negedge clk);
        chk("spi_start", 32'(spi_start), 1);
        chk("spi_nbytes", 32'(spi_num_bytes), 3);
        chk("spi_no_done", 32'(request_done), 0);
        chk("cs_idle_high", 32'(outputs), 32'h7);
        spi_busy = 1'b1;
        @(negedge clk);
        chk("cs_active_low", 32'(outputs), 32'h5);
        chk("spi_tx_data", spi_tx_data, 32'hDDCCBBAA);
        spi_rx_data = 32'h00123456;
        spi_done = 1'b1;
        @(negedge clk);
        chk("spi_req_done", 32'(request_done), 1);
        chk("spi_start_clr", 32'(spi_start), 0);
        spi_done = 1'b0;
        spi_busy = 1'b0;
        start_request = 1'b0;
        @(negedge clk);
        chk("cs_released", 32'(outputs), 32'h7);
        rd_chk("spi_rx", 8'h0C, 32'h00123456);
        rd_chk("spi_status", 8'h06, 32'h1);

        wr(8'h02, 32'h00);
        wr(8'h18, 32'h01);
        wr(8'h1A, 32'h00);
        rd_chk("rd_irq_en", 8'h18, 32'h01);
        io_inputs = 7'h51;
        repeat (5) @(negedge clk);
        chk("irq_set", 32'(irq), 1);
        rd_chk("pend0", 8'h19, 32'h01);
        wr(8'h19, 32'h01);
        chk("irq_clr", 32'(irq), 0);
        rd_chk("pend_cleared", 8'h19, 0);
        io_inputs = 7'h50;
        repeat (5) @(negedge clk);
        chk("fall_ignored", 32'(irq), 0);
        io_inputs = 7'h51;
        repeat (2) @(negedge clk);
        wr(8'h19, 32'h01);
        rd_chk("set_beats_w1c", 8'h19, 32'h01);
        chk("irq_kept", 32'(irq), 1);

        is_write = 1'b1;
        target_address = 8'h05;
        write_value = 32'h15;
        start_request = 1'b1;
        @(negedge clk);
        spi_busy = 1'b1;
        @(negedge clk);
        chk("pre_rst_spi", 32'(spi_start), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_spi_start", 32'(spi_start), 0);
        chk("rst_mid_done", 32'(request_done), 0);
        chk("rst_mid_outputs", 32'(outputs), 0);
        chk("rst_mid_irq", 32'(irq), 0);
        rst_n = 1'b1;
        start_request = 1'b0;
        spi_busy = 1'b0;
        @(negedge clk);
        bus(1'b0, 8'h02, '0, rd, lat);
        chk("post_rst_latency", 32'(lat), 1);
        chk("post_rst_dir", rd, 0);

        wr(8'h08, 32'h11223344);
        is_write = 1'b1;
        target_address = 8'h05;
        write_value = 32'h0B;
        start_request = 1'b1;
        @(negedge clk);
        chk("drop_spi_start", 32'(spi_start), 1);
        chk("drop_nbytes", 32'(spi_num_bytes), 2);
        start_request = 1'b0;
        repeat (2) @(negedge clk);
        chk("drop_still_busy", 32'(spi_start), 1);
        spi_rx_data = 32'hA5A5A5A5;
        spi_done = 1'b1;
        @(negedge clk);
        chk("drop_no_done", 32'(request_done), 0);
        chk("drop_start_clr", 32'(spi_start), 0);
        spi_done = 1'b0;
        @(negedge clk);
        chk("drop_no_done2", 32'(request_done), 0);
        bus(1'b0, 8'h0C, '0, rd, lat);
        chk("drop_rx", rd, 32'hA5A5A5A5);
        chk("drop_next_latency", 32'(lat), 1);
        rd_chk("drop_status", 8'h06, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/io_bus.md
Name: io_bus

Overview:
- Parametrised I/O-side register block and SPI-peripheral sequencer; the next generation of the I/O half of the memory bus.
- Serves CPU requests whose address MSB selects I/O space.
- Adds over the previous generation:
  - configurable pin and chip-select counts;
  - 1–4 byte SPI peripheral transfers through the shared SPI controller;
  - per-pin GPIO edge interrupts with a pending register.

Parameters:
NUM_GPIO, 7, bidirectional GPIO pins
NUM_OUT, 4, output-only pins (must be >= NUM_CS)
NUM_IN, 5, input-only pins
NUM_CS, 4, peripheral chip selects, mapped onto outputs[NUM_CS-1:0]
ADDR_W, 8, I/O register address width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start_request  in  1  CPU request; held high until request_done seen
is_write  in  1  1 = write, 0 = read
target_address  in  ADDR_W  register offset
write_value  in  32  write data
fetched_value  out  32  read data; zero-extended; valid while request_done=1
request_done  out  1  request complete; held until start_request drops
inputs  in  NUM_IN  input-only pins
outputs  out  NUM_OUT  output pins / chip selects
io_inputs  in  NUM_GPIO  GPIO pad inputs
io_outputs  out  NUM_GPIO  GPIO output values
io_direction  out  NUM_GPIO  1 = output
irq  out  1  |(irq_pend & irq_en)
spi_start  out  1  SPI controller peripheral request (level)
spi_num_bytes  out  3  bytes to transfer, 1..4
spi_tx_data  out  32  TX bytes; byte0 is sent first
spi_rx_data  in  32  RX bytes from controller
spi_done  in  1  controller transfer complete
spi_busy  in  1  controller in transaction

Behaviour:
- Reset (rst_n=0 at clk edge): all registers, request_done, spi_start, irq, io_outputs and io_direction are 0; state IDLE; outputs = 0.
- Input synchronisation: inputs and io_inputs pass through a 2-flop synchroniser.
  - IN reads the synchronised inputs.
  - GPIO_IN = synchronised io_inputs & ~dir.
- Register map (offset: access):
  - 0x00 OUT: RW, NUM_OUT bits.
  - 0x01 IN: RO.
  - 0x02 GPIO_DIR: RW.
  - 0x03 GPIO_IN: RO.
  - 0x04 GPIO_OUT: RW; stored as write_value & GPIO_DIR.
  - 0x05 SPI_CTRL: W only.
    - bit0 = start; bits[2:1] = nbytes-1.
    - bits[3+NUM_CS-1:3] = cs_sel, one-hot; 0 = none.
  - 0x06 SPI_STATUS: RO; bit0 = done, bit1 = busy.
  - 0x08 SPI_TX: RW, 32 bits.
  - 0x0C SPI_RX: RO, 32 bits.
  - 0x18 IRQ_EN: RW.
  - 0x19 IRQ_PEND: read; write-1-to-clear.
  - 0x1A IRQ_EDGE: RW; per pin, 0 = rising, 1 = falling.
  - Unmapped reads return 0; unmapped writes are ignored.
- FSM states: IDLE, SPI_WAIT, DONE.
  - IDLE with start_request=1, non-SPI access: perform access; next edge request_done=1 and fetched_value valid; go to DONE. Latency is 1 cycle.
  - IDLE with start_request=1, write to 0x05 with bit0=1:
    - latch nbytes, cs_sel; clear SPI done; set spi_start=1; go to SPI_WAIT.
  - SPI_WAIT with spi_done=1:
    - capture SPI_RX <= spi_rx_data; set SPI done; clear spi_start;
    - request_done=1; go to DONE.
  - DONE with start_request=0: request_done=0; go to IDLE.
  - start_request dropping in SPI_WAIT: the transfer still completes (RX captured, done set), request_done is not asserted, then IDLE.
  - Write to 0x05 with bit0=0: updates cs_sel only, completes in 1 cycle.
- Chip selects:
  - outputs[i] for i < NUM_CS: if cs_sel[i], outputs[i] = ~(spi_start & spi_busy), active low; otherwise OUT[i].
  - outputs[i] for i >= NUM_CS: OUT[i].
- Interrupts:
  - Edge detect on synchronised GPIO_IN versus its previous value, per IRQ_EDGE.
  - A detected edge sets the pend bit. If the edge and a W1C of the same bit occur in the same cycle, set wins.
  - irq is registered (1-cycle delay).
- Reset mid-SPI: spi_start deasserts immediately; the controller is expected to be reset by the same rst_n.

Decomposition:
- Package io_bus_pkg holds:
  - register offset localparams;
  - FSM state enum;
  - SPI_CTRL bit-field positions.
- One sub-module, gpio_edge_irq: synchroniser, edge detect, pend/en/edge registers and irq output; parametrised by NUM_GPIO.

Test Plan:
- Write 0x02 = 0x0F, then write 0x04 = 0x7F → io_outputs = 0x0F; request_done 1 cycle after start_request; readback of 0x04 = 0x0F.
- io_inputs = 0x50 with dir = 0x0F → after 2 sync cycles, read 0x03 = 0x50; read of 0x01 returns inputs; read of 0x30 returns 0.
- SPI_TX = 0xDDCCBBAA; write 0x05 = (cs_sel 0b0010, nbytes 3, start) → spi_start=1, spi_num_bytes=3, outputs[1] low while spi_busy; model returns spi_rx_data 0x00123456 with spi_done → request_done, SPI_RX = 0x00123456, SPI_STATUS bit0 = 1.
- IRQ_EN = 0x01, IRQ_EDGE = 0; io_inputs[0] goes 0→1 → pend[0] = 1, irq = 1; W1C 0x01 to 0x19 → irq = 0; a coincident new edge plus W1C leaves pend[0] = 1.
- rst_n low during SPI_WAIT → spi_start, request_done, outputs, irq all 0 on the next edge; state IDLE.
- Drop start_request mid-SPI → no request_done; after spi_done, SPI_RX captured, STATUS done = 1, next request serviced normally.
